imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe_if.sv | 30 +++
 rtl/imm_extend_pipe.sv | 119 +++++++++++
 tb/tb_imm_extend_pipe.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_if.sv
// Bus bundle for imm_extend_pipe: the decode request channel, the result channel and status.
// A transfer on either channel happens on a rising edge where valid && ready are both high.
// Valid never waits on ready, and the payload holds steady while valid is high and ready is low.
interface imm_extend_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr;
   logic [2:0]       ImmSrc;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  ImmExt;
   logic [TAG_W-1:0] out_tag;
   logic             imm_err;
   logic [2:0]       occupancy;

   modport master (
      output in_valid, instr, ImmSrc, in_tag, flush, out_ready,
      input  in_ready, out_valid, ImmExt, out_tag, imm_err, occupancy
   );

   modport slave (
      input  in_valid, instr, ImmSrc, in_tag, flush, out_ready,
      output in_ready, out_valid, ImmExt, out_tag, imm_err, occupancy
   );
endinterface

// File: rtl/imm_extend_pipe.sv
// RISC-V immediate decoder followed by an elastic, valid-tagged pipeline of STAGES registers.
// The decode is combinational at the input; each stage moves forward when the stage after it can take the entry.
module imm_extend_pipe #(
   parameter int XLEN   = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 32
) (
   input logic             clk,
   input logic             rst_n,
   imm_extend_pipe_if.slave bus
);
   localparam int LAST = STAGES - 1;

   logic [31:0]       w_imm32;
   logic              w_sext;
   logic              w_err;
   logic [XLEN-1:0]   w_dec;
   logic [STAGES-1:0] w_go;
   logic [STAGES-1:0] w_free;
   logic [STAGES-1:0] w_valid_nxt;
   logic [2:0]        w_occ_nxt;
   logic              w_accept;

   logic [STAGES-1:0] r_valid;
   logic [XLEN-1:0]   r_data [STAGES];
   logic [TAG_W-1:0]  r_tag  [STAGES];
   logic              r_err  [STAGES];
   logic [2:0]        r_occ;

   // Formats 0..4 are built as 32-bit values and sign-extended; shamt and zimm are zero-extended.
   always_comb begin
      w_imm32 = '0;
      w_sext  = 1'b1;
      w_err   = 1'b0;
      case (bus.ImmSrc)
         3'd0: w_imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
         3'd1: w_imm32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                          bus.instr[30:25], bus.instr[11:8], 1'b0};
         3'd2: w_imm32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
         3'd3: w_imm32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                          bus.instr[20], bus.instr[30:21], 1'b0};
         3'd4: w_imm32 = {bus.instr[31:12], 12'b0};
         3'd5: begin
            w_sext  = 1'b0;
            w_imm32 = (XLEN == 64) ? {26'b0, bus.instr[25:20]} : {27'b0, bus.instr[24:20]};
         end
         3'd6: begin
            w_sext  = 1'b0;
            w_imm32 = {27'b0, bus.instr[19:15]};
         end
         default: w_err = 1'b1;
      endcase
      w_dec = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);
   end

   // Backpressure ripples from the output towards stage 0 in a single cycle.
   always_comb begin : p_flow
      logic v_down_free;
      w_go        = '0;
      w_free      = '0;
      v_down_free = bus.out_ready;
      for (int k = LAST; k >= 0; k--) begin
         w_go[k]     = r_valid[k] && v_down_free;
         w_free[k]   = !r_valid[k] || w_go[k];
         v_down_free = w_free[k];
      end
   end

   assign bus.in_ready = rst_n && !bus.flush && w_free[0];
   assign w_accept     = bus.in_valid && bus.in_ready;

   always_comb begin
      w_valid_nxt    = '0;
      w_occ_nxt      = '0;
      w_valid_nxt[0] = w_accept || (r_valid[0] && !w_go[0]);
      for (int k = 1; k < STAGES; k++) begin
         w_valid_nxt[k] = w_go[k-1] || (r_valid[k] && !w_go[k]);
      end
      if (bus.flush) begin
         w_valid_nxt = '0;
      end
      for (int k = 0; k < STAGES; k++) begin
         w_occ_nxt = w_occ_nxt + 3'(w_valid_nxt[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_occ   <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_data[k] <= '0;
            r_tag[k]  <= '0;
            r_err[k]  <= 1'b0;
         end
      end else begin
         r_valid <= w_valid_nxt;
         r_occ   <= w_occ_nxt;
         if (w_accept) begin
            r_data[0] <= w_dec;
            r_tag[0]  <= bus.in_tag;
            r_err[0]  <= w_err;
         end
         for (int k = 1; k < STAGES; k++) begin
            if (w_go[k-1] && !bus.flush) begin
               r_data[k] <= r_data[k-1];
               r_tag[k]  <= r_tag[k-1];
               r_err[k]  <= r_err[k-1];
            end
         end
      end
   end

   assign bus.out_valid = r_valid[LAST];
   assign bus.ImmExt    = r_data[LAST];
   assign bus.out_tag   = r_tag[LAST];
   assign bus.imm_err   = r_err[LAST];
   assign bus.occupancy = r_occ;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: one 32-bit and one 64-bit instance, both two stages deep.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-2 units after it.
module tb_imm_extend_pipe;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   imm_extend_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
   imm_extend_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

   imm_extend_pipe #(.XLEN(32), .STAGES(2), .TAG_W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .bus(b32.slave));
   imm_extend_pipe #(.XLEN(64), .STAGES(2), .TAG_W(32)) dut64 (
      .clk(clk), .rst_n(rst_n), .bus(b64.slave));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      b32.in_valid = 1'b0; b32.instr = '0; b32.ImmSrc = '0; b32.in_tag = '0;
      b32.flush = 1'b0; b32.out_ready = 1'b1;
      b64.in_valid = 1'b0; b64.instr = '0; b64.ImmSrc = '0; b64.in_tag = '0;
      b64.flush = 1'b0; b64.out_ready = 1'b1;
   endtask

   task automatic push32(input logic [31:0] tag);
      b32.in_valid = 1'b1;
      b32.ImmSrc   = 3'd0;
      b32.instr    = {tag[11:0], 20'h00093};
      b32.in_tag   = tag;
   endtask

   task automatic test_reset();
      idle_inputs();
      #2;
      n_checks++; if (b32.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", b32.out_valid); else n_pass++;
      n_checks++; if (b32.ImmExt !== 32'h0) $display("FAIL rst_immext got=%h exp=0", b32.ImmExt); else n_pass++;
      n_checks++; if (b32.out_tag !== 32'h0) $display("FAIL rst_out_tag got=%h exp=0", b32.out_tag); else n_pass++;
      n_checks++; if (b32.imm_err !== 1'b0) $display("FAIL rst_imm_err got=%b exp=0", b32.imm_err); else n_pass++;
      n_checks++; if (b32.occupancy !== 3'd0) $display("FAIL rst_occupancy got=%0d exp=0", b32.occupancy); else n_pass++;
      n_checks++; if (b32.in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", b32.in_ready); else n_pass++;
      n_checks++; if (b64.ImmExt !== 64'h0) $display("FAIL rst_immext64 got=%h exp=0", b64.ImmExt); else n_pass++;
      step();
      step();
      rst_n = 1'b1;
      #1;
      n_checks++; if (b32.in_ready !== 1'b1) $display("FAIL rel_in_ready got=%b exp=1", b32.in_ready); else n_pass++;
      step();
   endtask

   task automatic test_decode32();
      logic [31:0] v_instr [9];
      logic [2:0]  v_src   [9];
      logic [31:0] v_imm   [9];
      logic        v_err   [9];
      v_instr = '{32'hFFF00093, 32'hFE000EE3, 32'hFE000EE3, 32'hFE112E23, 32'h0080006F,
                  32'h12345037, 32'h03F0D093, 32'h00075073, 32'h07B00093};
      v_src   = '{3'd0, 3'd1, 3'd7, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
      v_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000000, 32'hFFFFFFFC, 32'h00000008,
                  32'h12345000, 32'h0000001F, 32'h0000000E, 32'h0000007B};
      v_err   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      idle_inputs();
      for (int i = 0; i < 9; i++) begin
         b32.in_valid = 1'b1;
         b32.instr    = v_instr[i];
         b32.ImmSrc   = v_src[i];
         b32.in_tag   = 32'h100 + 32'(i);
         #1;
         n_checks++; if (b32.in_ready !== 1'b1) $display("FAIL dec_in_ready[%0d] got=%b exp=1", i, b32.in_ready); else n_pass++;
         step();
         b32.in_valid = 1'b0;
         n_checks++; if (b32.out_valid !== 1'b0) $display("FAIL dec_early_valid[%0d] got=%b exp=0", i, b32.out_valid); else n_pass++;
         step();
         n_checks++; if (b32.out_valid !== 1'b1) $display("FAIL dec_latency[%0d] got=%b exp=1", i, b32.out_valid); else n_pass++;
         n_checks++; if (b32.ImmExt !== v_imm[i]) $display("FAIL dec_immext[%0d] got=%h exp=%h", i, b32.ImmExt, v_imm[i]); else n_pass++;
         n_checks++; if (b32.imm_err !== v_err[i]) $display("FAIL dec_imm_err[%0d] got=%b exp=%b", i, b32.imm_err, v_err[i]); else n_pass++;
         n_checks++; if (b32.out_tag !== 32'h100 + 32'(i)) $display("FAIL dec_tag[%0d] got=%h exp=%h", i, b32.out_tag, 32'h100 + 32'(i)); else n_pass++;
         step();
      end
      n_checks++; if (b32.out_valid !== 1'b0) $display("FAIL dec_drain got=%b exp=0", b32.out_valid); else n_pass++;
   endtask

   task automatic test_decode64();
      logic [31:0] v_instr [4];
      logic [2:0]  v_src   [4];
      logic [63:0] v_imm   [4];
      v_instr = '{32'h800000B7, 32'h03F0D093, 32'hFFF00093, 32'h00075073};
      v_src   = '{3'd4, 3'd5, 3'd0, 3'd6};
      v_imm   = '{64'hFFFFFFFF80000000, 64'h000000000000003F, 64'hFFFFFFFFFFFFFFFF, 64'h000000000000000E};
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         b64.in_valid = 1'b1;
         b64.instr    = v_instr[i];
         b64.ImmSrc   = v_src[i];
         b64.in_tag   = 32'h40 + 32'(i);
         step();
         b64.in_valid = 1'b0;
         step();
         n_checks++; if (b64.out_valid !== 1'b1) $display("FAIL dec64_valid[%0d] got=%b exp=1", i, b64.out_valid); else n_pass++;
         n_checks++; if (b64.ImmExt !== v_imm[i]) $display("FAIL dec64_immext[%0d] got=%h exp=%h", i, b64.ImmExt, v_imm[i]); else n_pass++;
         step();
      end
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      b32.out_ready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         push32(32'(k));
         #1;
         if (k < 3) begin
            n_checks++; if (b32.in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d] got=%b exp=1", k, b32.in_ready); else n_pass++;
            step();
         end
      end
      n_checks++; if (b32.in_ready !== 1'b0) $display("FAIL b2b_full_in_ready got=%b exp=0", b32.in_ready); else n_pass++;
      n_checks++; if (b32.occupancy !== 3'd2) $display("FAIL b2b_occupancy got=%0d exp=2", b32.occupancy); else n_pass++;
      n_checks++; if (b32.out_tag !== 32'd1) $display("FAIL b2b_head_tag got=%h exp=1", b32.out_tag); else n_pass++;
      step();
      n_checks++; if (b32.out_valid !== 1'b1 || b32.out_tag !== 32'd1 || b32.ImmExt !== 32'd1)
         $display("FAIL b2b_hold got=%b/%h/%h exp=1/1/1", b32.out_valid, b32.out_tag, b32.ImmExt); else n_pass++;
      b32.out_ready = 1'b1;
      #1;
      n_checks++; if (b32.in_ready !== 1'b1) $display("FAIL b2b_release_in_ready got=%b exp=1", b32.in_ready); else n_pass++;
      step();
      b32.in_valid = 1'b0;
      n_checks++; if (b32.out_tag !== 32'd2 || b32.ImmExt !== 32'd2 || b32.out_valid !== 1'b1)
         $display("FAIL b2b_second got=%b/%h/%h exp=1/2/2", b32.out_valid, b32.out_tag, b32.ImmExt); else n_pass++;
      step();
      n_checks++; if (b32.out_tag !== 32'd3 || b32.ImmExt !== 32'd3 || b32.out_valid !== 1'b1)
         $display("FAIL b2b_third got=%b/%h/%h exp=1/3/3", b32.out_valid, b32.out_tag, b32.ImmExt); else n_pass++;
      step();
      n_checks++; if (b32.out_valid !== 1'b0) $display("FAIL b2b_empty got=%b exp=0", b32.out_valid); else n_pass++;
   endtask

   task automatic test_stream();
      logic [19:0] pat;
      int sent;
      int got;
      logic [31:0] exp_tag;
      pat  = 20'b1111_1111_1100_1011_0111;
      sent = 0;
      got  = 0;
      exp_q.delete();
      idle_inputs();
      for (int c = 0; c < 20; c++) begin
         if (sent < 6) push32(32'h200 + 32'(sent));
         else b32.in_valid = 1'b0;
         b32.out_ready = pat[c];
         #1;
         if (b32.out_valid && b32.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL stream_unexpected got=%h exp=none", b32.out_tag);
            end else begin
               exp_tag = exp_q.pop_front();
               if (b32.out_tag !== exp_tag || b32.ImmExt !== exp_tag)
                  $display("FAIL stream_order got=%h/%h exp=%h", b32.out_tag, b32.ImmExt, exp_tag);
               else n_pass++;
            end
            got++;
         end
         if (b32.in_valid && b32.in_ready) begin
            exp_q.push_back(32'h200 + 32'(sent));
            sent++;
         end
         step();
      end
      n_checks++; if (got != 6 || exp_q.size() != 0) $display("FAIL stream_count got=%0d exp=6 left=%0d", got, exp_q.size()); else n_pass++;
   endtask

   task automatic test_flush();
      idle_inputs();
      b32.out_ready = 1'b0;
      push32(32'h11);
      step();
      push32(32'h12);
      step();
      push32(32'h13);
      b32.flush = 1'b1;
      #1;
      n_checks++; if (b32.occupancy !== 3'd2) $display("FAIL flush_pre_occ got=%0d exp=2", b32.occupancy); else n_pass++;
      n_checks++; if (b32.in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b exp=0", b32.in_ready); else n_pass++;
      step();
      b32.flush     = 1'b0;
      b32.in_valid  = 1'b0;
      b32.out_ready = 1'b1;
      n_checks++; if (b32.occupancy !== 3'd0) $display("FAIL flush_occ got=%0d exp=0", b32.occupancy); else n_pass++;
      n_checks++; if (b32.out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", b32.out_valid); else n_pass++;
      for (int c = 0; c < 3; c++) begin
         step();
         n_checks++; if (b32.out_valid !== 1'b0) $display("FAIL flush_stale[%0d] got=%h exp=none", c, b32.out_tag); else n_pass++;
      end
      push32(32'h14);
      step();
      b32.in_valid = 1'b0;
      step();
      n_checks++; if (b32.out_valid !== 1'b1 || b32.out_tag !== 32'h14)
         $display("FAIL flush_recover got=%b/%h exp=1/14", b32.out_valid, b32.out_tag); else n_pass++;
      step();
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      b32.out_ready = 1'b0;
      push32(32'h21);
      step();
      push32(32'h22);
      step();
      b32.in_valid = 1'b0;
      n_checks++; if (b32.occupancy !== 3'd2) $display("FAIL rmid_pre_occ got=%0d exp=2", b32.occupancy); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++; if (b32.out_valid !== 1'b0) $display("FAIL rmid_out_valid got=%b exp=0", b32.out_valid); else n_pass++;
      n_checks++; if (b32.occupancy !== 3'd0) $display("FAIL rmid_occ got=%0d exp=0", b32.occupancy); else n_pass++;
      n_checks++; if (b32.ImmExt !== 32'h0 || b32.out_tag !== 32'h0)
         $display("FAIL rmid_data got=%h/%h exp=0/0", b32.ImmExt, b32.out_tag); else n_pass++;
      n_checks++; if (b32.in_ready !== 1'b0) $display("FAIL rmid_in_ready got=%b exp=0", b32.in_ready); else n_pass++;
      step();
      step();
      rst_n = 1'b1;
      b32.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         n_checks++; if (b32.out_valid !== 1'b0) $display("FAIL rmid_stale[%0d] got=%h exp=none", c, b32.out_tag); else n_pass++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_decode32();
      test_decode64();
      test_back_to_back();
      test_stream();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
